sdram_byte_port: RTL and testbench
==================================

Name: sdram_byte_port

Overview:
- Upstream client for one SDRAM controller channel.
- Converts 8-bit host byte accesses (NES CPU/PPU side) into 16-bit word requests with byte write masks.
- Holds a one-word read buffer so that consecutive bytes of the same word return without SDRAM traffic.
- One instance per controller channel, between the cartridge bus logic and the channel's request/ack port.

Parameters:
- ADDR_BITS, 24, SDRAM word-address width; host byte address is ADDR_BITS+1 bits.

Ports:
- clk  in  1  system clock (SDRAM clock domain)
- reset  in  1  synchronous, active-high reset
- host_req  in  1  single-cycle request strobe; sampled only when host_busy=0
- host_we  in  1  1=write, 0=read; qualified by host_req
- host_addr  in  ADDR_BITS+1  byte address; bit 0 selects the byte (0=low, 1=high)
- host_wdata  in  8  write byte
- host_rdata  out  8  read byte; valid in the host_ack cycle, held until the next ack
- host_ack  out  1  single-cycle completion pulse, for reads and writes
- host_busy  out  1  high while a request is in flight
- ram_req  out  1  single-cycle request pulse to the controller channel
- ram_we  out  1  write enable toward the controller
- ram_address  out  ADDR_BITS  word address
- ram_data_write  out  16  write word
- ram_wm  out  2  write mask; bit set = byte masked (bit0 low byte, bit1 high byte)
- ram_data_read  in  16  read word; valid in the ram_ack cycle
- ram_ack  in  1  single-cycle completion pulse from the controller

Behaviour:
- Reset values:
  - All outputs 0, including ram_wm=2'b00.
  - State IDLE.
  - Buffer valid=0, tag=0, data=0.
- Buffer: valid bit, tag = word address, 16-bit data. A hit is valid && tag==host_addr[ADDR_BITS:1].
- States: IDLE, RD_WAIT, WR_WAIT, ACK, plus PF_WAIT when PREFETCH_EN is defined.
- IDLE, read hit:
  - host_ack next cycle, host_rdata = selected byte.
  - No ram_req. host_busy stays 0.
- IDLE, read miss:
  - Next cycle: ram_req=1, ram_we=0, ram_wm=00, ram_address=host_addr[ADDR_BITS:1]. Go to RD_WAIT; host_busy=1 from this cycle.
  - On ram_ack: load buffer (valid=1, tag, data), latch the byte, go to ACK.
  - ACK: host_ack=1, host_busy=0, return to IDLE.
  - Total latency = SDRAM latency + 2 cycles.
- IDLE, write:
  - Next cycle: ram_req=1, ram_we=1, ram_data_write={wdata,wdata}, ram_wm = addr[0] ? 2'b01 : 2'b10. Go to WR_WAIT.
  - On a buffer hit at acceptance, update the addressed byte in the buffer in the same cycle, so buffer and memory stay coherent.
  - On ram_ack go to ACK, then host_ack and return to IDLE.
- ram_we, ram_address, ram_data_write and ram_wm hold their values from issue until ram_ack.
- Ignored inputs:
  - host_req while host_busy=1 is ignored; no state change, no ack.
  - ram_ack in IDLE or ACK is ignored, e.g. a stale ack after reset.
- Reset mid-operation: immediately return to IDLE, clear valid, drop host_busy. No host_ack for the aborted request.
- Each host request produces exactly one host_ack and at most one ram_req; prefetch adds one more ram_req, see below.

Optional Feature:
- Macro: SDRAM_BYTE_PORT_PREFETCH_EN.
- Defined:
  - Trigger: a read completion (hit or miss) of byte 1 (host_addr[0]=1).
  - Action: the cycle after host_ack, issue a background ram_req for word tag+1, wrapping from all-ones to 0. State PF_WAIT, host_busy=1.
  - On ram_ack: replace the buffer with tag+1, return to IDLE, no host_ack.
  - Result: sequential byte reads hit after the first word.
- Undefined: no PF_WAIT state; no ram_req is issued without a host request.

Test Plan:
- Reset, then read 0x000 with SDRAM word 0 = 0xF7F8 -> one ram_req (addr 0, we=0); host_rdata=0xF8; buffer valid.
- Then read 0x001 -> host_ack 1 cycle after req, host_rdata=0xF7, no ram_req.
- Write 0x5A to byte 0x003 -> ram_address=1, ram_data_write=0x5A5A, ram_wm=2'b01. Reading 0x003 then returns 0x5A. Reading 0x002 returns the prior low byte, unchanged.
- Write a byte within the buffered word 0 -> buffer updated. The following read of that byte hits with no ram_req and returns the new value.
- Pulse host_req during RD_WAIT -> ignored: exactly one host_ack, one ram_req. Assert reset during WR_WAIT -> host_busy=0 next cycle, valid=0, late ram_ack produces no host_ack.
- PREFETCH_EN: read byte address all-ones (word 0xFFFFFF) -> after host_ack, ram_req to address 0. A subsequent read of 0x000 hits with no ram_req.

Source files
------------

// File: rtl/sdram_byte_port_if.sv
// Bundle for sdram_byte_port: the 8-bit host byte port plus the 16-bit
// request/ack channel toward one SDRAM controller channel.
// "slave" is the view taken by sdram_byte_port itself; "master" is the view of
// the surrounding logic (cartridge bus on the host side, controller on the
// RAM side).
interface sdram_byte_port_if #(
    parameter int ADDR_BITS = 24
);
    // host side
    logic                 host_req;
    logic                 host_we;
    logic [ADDR_BITS:0]   host_addr;
    logic [7:0]           host_wdata;
    logic [7:0]           host_rdata;
    logic                 host_ack;
    logic                 host_busy;
    // controller channel side
    logic                 ram_req;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_address;
    logic [15:0]          ram_data_write;
    logic [1:0]           ram_wm;
    logic [15:0]          ram_data_read;
    logic                 ram_ack;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack, host_busy,
        output ram_req, ram_we, ram_address, ram_data_write, ram_wm,
        input  ram_data_read, ram_ack
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack, host_busy,
        input  ram_req, ram_we, ram_address, ram_data_write, ram_wm,
        output ram_data_read, ram_ack
    );
endinterface

// File: rtl/sdram_byte_port.sv
// sdram_byte_port: turns 8-bit host byte reads/writes into 16-bit SDRAM word
// requests with byte write masks, and keeps a one-word read buffer so that the
// second byte of a word (and rereads) come back without touching SDRAM.
// Writes go straight through to SDRAM; a write that hits the buffered word
// patches the buffer as well so the two never disagree.
// Optional feature: define SDRAM_BYTE_PORT_PREFETCH_EN to fetch word tag+1
// in the background after every completed read of byte 1 (high byte).
module sdram_byte_port #(
    parameter int ADDR_BITS = 24
) (
    input  logic             clk,
    input  logic             reset,
    sdram_byte_port_if.slave io_bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
    localparam logic [2:0] S_PF_WAIT = 3'd4;
    localparam logic [ADDR_BITS-1:0] WORD_ONE = ADDR_BITS'(1);
`endif

    logic [2:0]           r_state;

    // one-word read buffer
    logic                 r_valid;
    logic [ADDR_BITS-1:0] r_tag;
    logic [15:0]          r_data;

    // host result and the byte lane of the request in flight
    logic [7:0]           r_rdata;
    logic                 r_byte_sel;

    // controller channel request registers (held from issue until ram_ack)
    logic                 r_ram_req;
    logic                 r_ram_we;
    logic [ADDR_BITS-1:0] r_ram_addr;
    logic [15:0]          r_ram_wdata;
    logic [1:0]           r_ram_wm;

`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
    // set when the completion now being acknowledged was a byte-1 read
    logic                 r_pf_pending;
`endif

    logic [ADDR_BITS-1:0] w_word;
    logic                 w_byte;
    logic                 w_hit;
    logic [7:0]           w_hit_byte;

    assign w_word     = io_bus.host_addr[ADDR_BITS:1];
    assign w_byte     = io_bus.host_addr[0];
    assign w_hit      = r_valid && (r_tag == w_word);
    assign w_hit_byte = w_byte ? r_data[15:8] : r_data[7:0];

    // Request sequencing, buffer maintenance and controller handshake.
    // The ACK cycle already reports host_busy=0, so a host request arriving in
    // it is accepted exactly like one in IDLE; with prefetch enabled such a
    // request takes priority and the pending prefetch is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_tag       <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_byte_sel  <= 1'b0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_wm    <= 2'b00;
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
            r_pf_pending <= 1'b0;
`endif
        end else begin
            r_ram_req <= 1'b0;
            case (r_state)
                S_IDLE, S_ACK: begin
                    r_state <= S_IDLE;
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
                    r_pf_pending <= 1'b0;
`endif
                    if (io_bus.host_req) begin
                        r_byte_sel <= w_byte;
                        if (io_bus.host_we) begin
                            r_ram_req   <= 1'b1;
                            r_ram_we    <= 1'b1;
                            r_ram_addr  <= w_word;
                            r_ram_wdata <= {io_bus.host_wdata, io_bus.host_wdata};
                            // mask the lane that is NOT being written
                            r_ram_wm    <= w_byte ? 2'b01 : 2'b10;
                            r_state     <= S_WR_WAIT;
                            if (w_hit) begin
                                if (w_byte) begin
                                    r_data[15:8] <= io_bus.host_wdata;
                                end else begin
                                    r_data[7:0] <= io_bus.host_wdata;
                                end
                            end
                        end else if (w_hit) begin
                            r_rdata <= w_hit_byte;
                            r_state <= S_ACK;
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
                            r_pf_pending <= w_byte;
`endif
                        end else begin
                            r_ram_req  <= 1'b1;
                            r_ram_we   <= 1'b0;
                            r_ram_addr <= w_word;
                            r_ram_wm   <= 2'b00;
                            r_state    <= S_RD_WAIT;
                        end
                    end
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
                    else if ((r_state == S_ACK) && r_pf_pending) begin
                        // background fetch of the following word; wraps at the top
                        r_ram_req  <= 1'b1;
                        r_ram_we   <= 1'b0;
                        r_ram_addr <= r_tag + WORD_ONE;
                        r_ram_wm   <= 2'b00;
                        r_state    <= S_PF_WAIT;
                    end
`endif
                end

                S_RD_WAIT: begin
                    if (io_bus.ram_ack) begin
                        r_valid <= 1'b1;
                        r_tag   <= r_ram_addr;
                        r_data  <= io_bus.ram_data_read;
                        r_rdata <= r_byte_sel ? io_bus.ram_data_read[15:8]
                                              : io_bus.ram_data_read[7:0];
                        r_state <= S_ACK;
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
                        r_pf_pending <= r_byte_sel;
`endif
                    end
                end

                S_WR_WAIT: begin
                    if (io_bus.ram_ack) begin
                        r_state <= S_ACK;
                    end
                end

`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
                S_PF_WAIT: begin
                    if (io_bus.ram_ack) begin
                        r_valid <= 1'b1;
                        r_tag   <= r_ram_addr;
                        r_data  <= io_bus.ram_data_read;
                        r_state <= S_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.host_rdata = r_rdata;
    assign io_bus.host_ack   = (r_state == S_ACK);
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
    assign io_bus.host_busy  = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT) ||
                               (r_state == S_PF_WAIT);
`else
    assign io_bus.host_busy  = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
`endif

    assign io_bus.ram_req        = r_ram_req;
    assign io_bus.ram_we         = r_ram_we;
    assign io_bus.ram_address    = r_ram_addr;
    assign io_bus.ram_data_write = r_ram_wdata;
    assign io_bus.ram_wm         = r_ram_wm;

endmodule

// File: tb/tb_sdram_byte_port.sv
// Testbench for sdram_byte_port: directed scenarios followed by random byte
// traffic. A byte-addressed reference memory plus a "which word is buffered"
// model predicts every host completion and every SDRAM request; a monitor and
// an SDRAM responder pop and compare independently of the stimulus.
module tb_sdram_byte_port;
    localparam int AB = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdram_byte_port_if #(.ADDR_BITS(AB)) bus ();

    sdram_byte_port #(.ADDR_BITS(AB)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    typedef struct {
        bit          is_read;
        logic [7:0]  rdata;
        bit          hit;
        int          issue_cyc;
        logic [AB:0] addr;
    } ack_t;

    typedef struct {
        bit            we;
        logic [AB-1:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    wm;
    } ram_t;

    ack_t ack_q[$];
    ram_t ram_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acks_seen = 0;
    int acks_target = 0;
    int last_lat = 1;
    int force_lat = 0;

    logic [15:0] sd_mem [logic [AB-1:0]];
    logic [7:0]  ref_mem [logic [AB:0]];
    bit          buf_valid = 1'b0;
    logic [AB-1:0] buf_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // power-on contents of the SDRAM; word 0 is fixed at 0xF7F8
    function automatic logic [15:0] init_word(input logic [AB-1:0] wa);
        logic [31:0] h;
        if (wa == '0) return 16'hF7F8;
        h = 32'(wa) * 32'd40503 + 32'd12345;
        return h[15:0] ^ h[31:16];
    endfunction

    function automatic logic [7:0] ref_byte(input logic [AB:0] a);
        logic [15:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word(a[AB:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // Predict the outcome of one host request from the byte-level view.
    task automatic model_issue(input bit we, input logic [AB:0] addr, input logic [7:0] wd,
                               input bit push_ack);
        ack_t a;
        ram_t r;
        logic [AB-1:0] w;
        w = addr[AB:1];
        a.is_read = !we;
        a.addr = addr;
        a.issue_cyc = cyc;
        a.hit = 1'b0;
        a.rdata = 8'h00;
        if (we) begin
            r.we = 1'b1; r.addr = w; r.wdata = {wd, wd};
            r.wm = addr[0] ? 2'b01 : 2'b10;
            ram_q.push_back(r);
            ref_mem[addr] = wd;
        end else begin
            a.rdata = ref_byte(addr);
            a.hit = buf_valid && (buf_word == w);
            if (!a.hit) begin
                r.we = 1'b0; r.addr = w; r.wdata = 16'h0; r.wm = 2'b00;
                ram_q.push_back(r);
                buf_valid = 1'b1;
                buf_word = w;
            end
`ifdef SDRAM_BYTE_PORT_PREFETCH_EN
            if (addr[0]) begin
                r.we = 1'b0; r.addr = w + AB'(1); r.wdata = 16'h0; r.wm = 2'b00;
                ram_q.push_back(r);
                buf_valid = 1'b1;
                buf_word = w + AB'(1);
            end
`endif
        end
        if (push_ack) ack_q.push_back(a);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.host_busy) break;
        end
        if (bus.host_busy) chk("busy_timeout", 32'(bus.host_busy), 32'd0);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 200 && acks_seen < acks_target; i++) @(posedge clk);
        if (acks_seen < acks_target) begin
            chk("ack_timeout", 32'(acks_seen), 32'(acks_target));
            acks_target = acks_seen;
        end
    endtask

    task automatic do_req(input bit we, input logic [AB:0] addr, input logic [7:0] wd,
                          input bit poke);
        wait_idle();
        model_issue(we, addr, wd, 1'b1);
        acks_target++;
        bus.host_req = 1'b1;
        bus.host_we = we;
        bus.host_addr = addr;
        bus.host_wdata = wd;
        @(posedge clk);
        #1;
        bus.host_req = 1'b0;
        if (poke) begin
            // a request while busy must be ignored entirely
            @(negedge clk);
            if (bus.host_busy) begin
                bus.host_req = 1'b1;
                bus.host_we = 1'($urandom_range(0, 1));
                bus.host_addr = (AB + 1)'($urandom);
                bus.host_wdata = 8'($urandom);
                @(posedge clk);
                #1;
                bus.host_req = 1'b0;
            end
        end
        wait_ack();
    endtask

    // host completion monitor
    initial begin
        ack_t a;
        forever begin
            @(negedge clk);
            if (bus.host_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 32'(bus.host_ack), 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    if (a.is_read) chk("rdata", 32'(bus.host_rdata), 32'(a.rdata));
                    chk("ack_latency", 32'(cyc - a.issue_cyc), a.hit ? 32'd1 : 32'(last_lat + 2));
                    chk("busy_in_ack", 32'(bus.host_busy), 32'd0);
                    $display("[TB] ack addr=0x%0h %s data=0x%02h %s", a.addr,
                             a.is_read ? "RD" : "WR", bus.host_rdata, a.hit ? "hit" : "sdram");
                    acks_seen++;
                end
            end
        end
    end

    // SDRAM controller channel responder
    initial begin
        ram_t e;
        int lat;
        logic [AB-1:0] a;
        logic [15:0] w;
        bus.ram_ack = 1'b0;
        bus.ram_data_read = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.ram_req) begin
                a = bus.ram_address;
                if (ram_q.size() == 0) begin
                    chk("unexpected_ram_req", 32'(bus.ram_req), 32'd0);
                end else begin
                    e = ram_q.pop_front();
                    chk("ram_we", 32'(bus.ram_we), 32'(e.we));
                    chk("ram_address", 32'(bus.ram_address), 32'(e.addr));
                    chk("ram_wm", 32'(bus.ram_wm), 32'(e.wm));
                    if (e.we) chk("ram_data_write", 32'(bus.ram_data_write), 32'(e.wdata));
                end
                w = sd_mem.exists(a) ? sd_mem[a] : init_word(a);
                if (bus.ram_we) begin
                    if (!bus.ram_wm[0]) w[7:0] = bus.ram_data_write[7:0];
                    if (!bus.ram_wm[1]) w[15:8] = bus.ram_data_write[15:8];
                    sd_mem[a] = w;
                end
                lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
                last_lat = lat;
                repeat (lat) @(negedge clk);
                if (force_lat == 0) chk("ram_address_hold", 32'(bus.ram_address), 32'(a));
                bus.ram_data_read = w;
                bus.ram_ack = 1'b1;
                @(negedge clk);
                bus.ram_ack = 1'b0;
                bus.ram_data_read = 16'($urandom);
            end
        end
    end

    logic [AB:0] ones_addr;

    initial begin
        bus.host_req = 1'b0;
        bus.host_we = 1'b0;
        bus.host_addr = '0;
        bus.host_wdata = 8'h00;
        ones_addr = '1;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
        chk("rst_host_busy", 32'(bus.host_busy), 32'd0);
        chk("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
        chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_address", 32'(bus.ram_address), 32'd0);
        chk("rst_ram_data_write", 32'(bus.ram_data_write), 32'd0);
        chk("rst_ram_wm", 32'(bus.ram_wm), 32'd0);

        // word 0 miss, then the other byte hits
        do_req(1'b0, 25'h000, 8'h00, 1'b0);
        do_req(1'b0, 25'h001, 8'h00, 1'b0);
        // write-through to a non-buffered word, then read both bytes back
        do_req(1'b1, 25'h003, 8'h5A, 1'b0);
        do_req(1'b0, 25'h003, 8'h00, 1'b0);
        do_req(1'b0, 25'h002, 8'h00, 1'b0);
        // write into the buffered word keeps the buffer coherent
        do_req(1'b0, 25'h000, 8'h00, 1'b0);
        do_req(1'b1, 25'h000, 8'h11, 1'b0);
        do_req(1'b0, 25'h000, 8'h00, 1'b0);
        // host request while busy is ignored
        do_req(1'b0, 25'h004, 8'h00, 1'b1);

        // reset during WR_WAIT: no ack, buffer invalidated, late ram_ack ignored
        wait_idle();
        model_issue(1'b1, 25'h006, 8'hC3, 1'b0);
        buf_valid = 1'b0;
        force_lat = 3;
        bus.host_req = 1'b1;
        bus.host_we = 1'b1;
        bus.host_addr = 25'h006;
        bus.host_wdata = 8'hC3;
        @(posedge clk);
        #1;
        bus.host_req = 1'b0;
        @(negedge clk);
        chk("busy_wr_wait", 32'(bus.host_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("busy_after_rst", 32'(bus.host_busy), 32'd0);
        chk("ack_after_rst", 32'(bus.host_ack), 32'd0);
        repeat (6) @(negedge clk);
        force_lat = 0;
        do_req(1'b0, 25'h004, 8'h00, 1'b0);
        do_req(1'b0, 25'h006, 8'h00, 1'b0);

        // top of the address space, then word 0
        do_req(1'b0, ones_addr, 8'h00, 1'b0);
        do_req(1'b0, 25'h000, 8'h00, 1'b0);

        // random traffic over a small window so hits are frequent
        for (int t = 0; t < 300; t++) begin
            int sel;
            logic [AB:0] addr;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) addr = (AB + 1)'($urandom);
            else if (sel == 1) addr = ones_addr - (AB + 1)'($urandom_range(0, 2));
            else addr = (AB + 1)'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req($urandom_range(0, 2) == 0, addr, 8'($urandom), $urandom_range(0, 7) == 0);
        end

        repeat (20) @(negedge clk);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("ram_queue_drained", 32'(ram_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
